// File: rtl/w_mem_writer_pkg.sv
// Shared types for the W-channel memory writer: response codes, burst codes and FSM states.
package w_mem_writer_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic burst_supported(input logic [1:0] burst);
    return (burst == BURST_FIXED) || (burst == BURST_INCR);
  endfunction

endpackage

// File: rtl/w_mem_writer_if.sv
// Command, W-beat, memory-write and response signals of the W-channel memory writer.
interface w_mem_writer_if
  import w_mem_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) ();

  // aw, in_W and b channels: a transfer happens on a rising edge where valid and
  // ready are both high; valid never waits on ready, payload is held while valid is high.
  logic                  aw_valid;
  logic                  aw_ready;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [1:0]            aw_burst;

  logic [DATA_WIDTH-1:0] in_WDATA;
  logic [STRB_WIDTH-1:0] in_WSTRB;
  logic                  in_WLAST;
  logic                  in_WVALID;
  logic                  in_WREADY;

  logic                  mem_en;
  logic [STRB_WIDTH-1:0] mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  logic                  busy;
  state_t                dbg_state;

  modport slave (
    input  aw_valid, aw_addr, aw_len, aw_burst,
    input  in_WDATA, in_WSTRB, in_WLAST, in_WVALID,
    input  b_ready,
    output aw_ready, in_WREADY,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output b_valid, b_resp, busy, dbg_state
  );

  modport master (
    output aw_valid, aw_addr, aw_len, aw_burst,
    output in_WDATA, in_WSTRB, in_WLAST, in_WVALID,
    output b_ready,
    input  aw_ready, in_WREADY,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  b_valid, b_resp, busy, dbg_state
  );

endinterface

// File: rtl/w_addr_gen.sv
// Beat address generator: loads the aligned start address, steps it for INCR bursts, flags range.
module w_addr_gen
  import w_mem_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = 4,
  parameter int MEM_BYTES  = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_addr,
  input  logic [1:0]            i_burst,
  input  logic                  i_advance,
  output logic [ADDR_WIDTH-1:0] o_cur_addr,
  output logic                  o_in_range
);

  localparam logic [ADDR_WIDTH:0]   LIMIT = (ADDR_WIDTH+1)'(MEM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] STEP  = ADDR_WIDTH'(STRB_WIDTH);

  logic [ADDR_WIDTH-1:0] r_cur_addr;

  // Addition wraps naturally at 2^ADDR_WIDTH.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_addr <= '0;
    end else if (i_load) begin
      r_cur_addr <= i_load_addr;
    end else if (i_advance && (i_burst == BURST_INCR)) begin
      r_cur_addr <= r_cur_addr + STEP;
    end
  end

  assign o_cur_addr = r_cur_addr;
  assign o_in_range = {1'b0, r_cur_addr} < LIMIT;

endmodule

// File: rtl/w_mem_writer.sv
// Pairs one write command with its W beats, issues byte-masked memory writes, returns one B per burst.
// Optional burst/error counters are enabled with W_MEM_WRITER_STATS_EN.
module w_mem_writer
  import w_mem_writer_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int MEM_BYTES  = 4096
) (
  input  logic            W_mc_clk,
  input  logic            W_mc_rst,
  w_mem_writer_if.slave   bus
`ifdef W_MEM_WRITER_STATS_EN
  ,
  output logic [15:0]     stat_bursts,
  output logic [15:0]     stat_errors
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(STRB_WIDTH - 1);

  state_t                r_state;
  logic [7:0]            r_len;
  logic [1:0]            r_burst;
  logic [8:0]            r_beat_cnt;
  logic                  r_err;
  logic                  r_mem_en;
  logic [STRB_WIDTH-1:0] r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_b_valid;
  resp_t                 r_b_resp;

  logic [ADDR_WIDTH-1:0] w_cur_addr;
  logic                  w_in_range;
  logic                  w_aw_ready;
  logic                  w_aw_hs;
  logic                  w_beat;
  logic                  w_last;
  logic                  w_burst_ok;
  logic                  w_write;
  logic                  w_beat_err;

  assign w_aw_ready = (r_state == IDLE) && !W_mc_rst;
  assign w_aw_hs    = bus.aw_valid && w_aw_ready;
  assign w_beat     = bus.in_WVALID && (r_state == DATA) && !W_mc_rst;
  assign w_last     = (r_beat_cnt == {1'b0, r_len});
  assign w_burst_ok = burst_supported(r_burst);
  assign w_write    = w_burst_ok && w_in_range;
  // WLAST must agree with the length count; disagreement flags the burst but never ends it.
  assign w_beat_err = (bus.in_WLAST != w_last) || !w_write;

  w_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .MEM_BYTES  (MEM_BYTES)
  ) u_addr_gen (
    .i_clk       (W_mc_clk),
    .i_rst       (W_mc_rst),
    .i_load      (w_aw_hs),
    .i_load_addr (bus.aw_addr & ALIGN_MASK),
    .i_burst     (r_burst),
    .i_advance   (w_beat),
    .o_cur_addr  (w_cur_addr),
    .o_in_range  (w_in_range)
  );

  always_ff @(posedge W_mc_clk) begin
    if (W_mc_rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_burst     <= '0;
      r_beat_cnt  <= '0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_b_valid   <= 1'b0;
      r_b_resp    <= OKAY;
    end else begin
      r_mem_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.aw_valid) begin
            r_len      <= bus.aw_len;
            r_burst    <= bus.aw_burst;
            r_beat_cnt <= '0;
            r_err      <= 1'b0;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (bus.in_WVALID) begin
            r_mem_en    <= w_write;
            r_mem_we    <= w_write ? bus.in_WSTRB : '0;
            r_mem_addr  <= w_cur_addr;
            r_mem_wdata <= bus.in_WDATA;
            r_beat_cnt  <= r_beat_cnt + 9'd1;
            r_err       <= r_err | w_beat_err;
            if (w_last) begin
              r_b_valid <= 1'b1;
              r_b_resp  <= (r_err || w_beat_err) ? SLVERR : OKAY;
              r_state   <= RESP;
            end
          end
        end
        RESP: begin
          if (bus.b_ready) begin
            r_b_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.aw_ready  = w_aw_ready;
  assign bus.in_WREADY = (r_state == DATA) && !W_mc_rst;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.b_valid   = r_b_valid;
  assign bus.b_resp    = r_b_resp;
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;

`ifdef W_MEM_WRITER_STATS_EN
  logic [15:0] r_stat_bursts;
  logic [15:0] r_stat_errors;
  logic        w_b_hs;

  assign w_b_hs = r_b_valid && bus.b_ready;

  always_ff @(posedge W_mc_clk) begin
    if (W_mc_rst) begin
      r_stat_bursts <= '0;
      r_stat_errors <= '0;
    end else if (w_b_hs) begin
      if (r_stat_bursts != 16'hFFFF) r_stat_bursts <= r_stat_bursts + 16'd1;
      if ((r_b_resp == SLVERR) && (r_stat_errors != 16'hFFFF)) r_stat_errors <= r_stat_errors + 16'd1;
    end
  end

  assign stat_bursts = r_stat_bursts;
  assign stat_errors = r_stat_errors;
`endif

endmodule

// File: tb/tb_w_mem_writer.sv
// Directed bench for w_mem_writer: drivers push expected writes/responses, a negedge monitor checks them.
module tb_w_mem_writer;
  import w_mem_writer_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int MEM_BYTES = 4096;
  localparam int MW = AW + SW + DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  w_mem_writer_if bus ();

`ifdef W_MEM_WRITER_STATS_EN
  logic [15:0] stat_bursts;
  logic [15:0] stat_errors;
`endif

  w_mem_writer dut (
    .W_mc_clk (clk),
    .W_mc_rst (rst),
    .bus      (bus)
`ifdef W_MEM_WRITER_STATS_EN
    ,
    .stat_bursts (stat_bursts),
    .stat_errors (stat_errors)
`endif
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  int run_len = 0;
  int run_max = 0;
  logic [MW-1:0] exp_q[$];
  logic [1:0]    exp_b_q[$];

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: no DUT response within cycle budget at %0t", name, $time);
  endtask

  // Monitor: compares every memory write and B handshake against the queues.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        run_len++;
        if (run_len > run_max) run_max = run_len;
        if (exp_q.size() == 0) check("unexpected_write", MW'(bus.mem_en), '0);
        else check("mem_write", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, exp_q.pop_front());
      end else begin
        run_len = 0;
      end
      if (bus.b_valid === 1'b1 && bus.b_ready === 1'b1) begin
        if (exp_b_q.size() == 0) check("unexpected_b", MW'(bus.b_valid), '0);
        else check("b_resp", MW'(bus.b_resp), MW'(exp_b_q.pop_front()));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- drivers (entered at posedge+1) ----------------
  task automatic send_aw(input logic [AW-1:0] addr, input logic [7:0] len, input logic [1:0] burst);
    logic done;
    done = 1'b0;
    bus.aw_valid = 1'b1;
    bus.aw_addr  = addr;
    bus.aw_len   = len;
    bus.aw_burst = burst;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.aw_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) timeout("aw_handshake");
    bus.aw_valid = 1'b0;
  endtask

  task automatic send_beat(input int gap, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic last, input logic exp_en, input logic [AW-1:0] exp_addr);
    logic done;
    done = 1'b0;
    bus.in_WVALID = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    bus.in_WVALID = 1'b1;
    bus.in_WDATA  = d;
    bus.in_WSTRB  = s;
    bus.in_WLAST  = last;
    if (exp_en) exp_q.push_back({exp_addr, s, d});
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.in_WREADY) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) timeout("w_handshake");
    bus.in_WVALID = 1'b0;
    bus.in_WLAST  = 1'b0;
  endtask

  task automatic wait_b(input int hold, input logic [1:0] exp_resp);
    int lat;
    logic got;
    logic [1:0] resp0;
    got = 1'b0;
    lat = 0;
    exp_b_q.push_back(exp_resp);
    while (lat < 50 && !got) begin
      @(negedge clk);
      if (bus.b_valid) got = 1'b1;
      else lat++;
    end
    if (!got) begin
      timeout("b_valid");
      void'(exp_b_q.pop_back());
    end else begin
      check("b_latency", MW'(lat), '0);
      resp0 = bus.b_resp;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check("b_valid_hold", MW'(bus.b_valid), MW'(1));
        check("b_resp_hold", MW'(bus.b_resp), MW'(resp0));
        check("aw_ready_in_resp", MW'(bus.aw_ready), '0);
      end
      @(posedge clk);
      #1;
      bus.b_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.b_ready = 1'b0;
      @(negedge clk);
      check("aw_ready_after_b", MW'(bus.aw_ready), MW'(1));
      check("b_valid_cleared", MW'(bus.b_valid), '0);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bus.aw_valid  = 1'b0;
    bus.aw_addr   = '0;
    bus.aw_len    = '0;
    bus.aw_burst  = '0;
    bus.in_WVALID = 1'b0;
    bus.in_WDATA  = '0;
    bus.in_WSTRB  = '0;
    bus.in_WLAST  = 1'b0;
    bus.b_ready   = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_aw_ready", MW'(bus.aw_ready), '0);
    check("rst_wready", MW'(bus.in_WREADY), '0);
    check("rst_mem_en", MW'(bus.mem_en), '0);
    check("rst_b_valid", MW'(bus.b_valid), '0);
    check("rst_busy", MW'(bus.busy), '0);
    check("rst_outputs", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single beat
    send_aw(32'h10, 8'd0, BURST_INCR);
    send_beat(0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b1, 32'h10);
    wait_b(0, OKAY);

    // unaligned start address is aligned down
    send_aw(32'h43, 8'd0, BURST_INCR);
    send_beat(0, 32'h11223344, 4'h3, 1'b1, 1'b1, 32'h40);
    wait_b(0, OKAY);

    // all-zero strobe still pulses mem_en
    send_aw(32'h50, 8'd0, BURST_FIXED);
    send_beat(0, 32'hCAFEF00D, 4'h0, 1'b1, 1'b1, 32'h50);
    wait_b(0, OKAY);

    // INCR, back-to-back beats
    run_max = 0;
    send_aw(32'h100, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++)
      send_beat(0, 32'hA0 + i, 4'hF, i == 3, 1'b1, 32'h100 + 4 * i);
    wait_b(0, OKAY);
    check("incr_back_to_back", MW'(run_max), MW'(4));

    // FIXED with 2-cycle gaps
    run_max = 0;
    send_aw(32'h20, 8'd2, BURST_FIXED);
    for (int i = 0; i < 3; i++)
      send_beat(i == 0 ? 0 : 2, 32'hB0 + i, 4'h5, i == 2, 1'b1, 32'h20);
    wait_b(0, OKAY);
    check("fixed_bubbles", MW'(run_max), MW'(1));

    // early WLAST on beat 2 of 4
    send_aw(32'h200, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++)
      send_beat(0, 32'hC0 + i, 4'hF, i == 1, 1'b1, 32'h200 + 4 * i);
    wait_b(0, SLVERR);

    // missing WLAST
    send_aw(32'h300, 8'd1, BURST_INCR);
    send_beat(0, 32'hD0, 4'hF, 1'b0, 1'b1, 32'h300);
    send_beat(0, 32'hD1, 4'hF, 1'b0, 1'b1, 32'h304);
    wait_b(0, SLVERR);

    // second beat crosses MEM_BYTES
    send_aw(32'(MEM_BYTES - 4), 8'd1, BURST_INCR);
    send_beat(0, 32'hE0, 4'hF, 1'b0, 1'b1, 32'(MEM_BYTES - 4));
    send_beat(0, 32'hE1, 4'hF, 1'b1, 1'b0, 32'h0);
    wait_b(0, SLVERR);

    // unsupported burst type: beats consumed, nothing written
    send_aw(32'h80, 8'd1, 2'b10);
    send_beat(0, 32'hF0, 4'hF, 1'b0, 1'b0, 32'h0);
    send_beat(0, 32'hF1, 4'hF, 1'b1, 1'b0, 32'h0);
    wait_b(0, SLVERR);

    // B backpressure for 5 cycles
    send_aw(32'h500, 8'd0, BURST_INCR);
    send_beat(0, 32'h12345678, 4'hC, 1'b1, 1'b1, 32'h500);
    wait_b(5, OKAY);

    // reset after beat 2 of an 8-beat burst
    send_aw(32'h400, 8'd7, BURST_INCR);
    send_beat(0, 32'h40, 4'hF, 1'b0, 1'b1, 32'h400);
    send_beat(0, 32'h41, 4'hF, 1'b0, 1'b1, 32'h404);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_wready", MW'(bus.in_WREADY), '0);
    check("midrst_aw_ready", MW'(bus.aw_ready), '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("midrst_mem_en", MW'(bus.mem_en), '0);
    check("midrst_b_valid", MW'(bus.b_valid), '0);
    check("midrst_state", MW'(bus.dbg_state), MW'(IDLE));
    check("midrst_outputs", {bus.mem_addr, bus.mem_we, bus.mem_wdata}, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_aw_ready", MW'(bus.aw_ready), MW'(1));
      check("post_rst_no_b", MW'(bus.b_valid), '0);
    end
    @(posedge clk);
    #1;

    // normal burst after the abort
    send_aw(32'h600, 8'd1, BURST_INCR);
    send_beat(0, 32'h600DF00D, 4'hF, 1'b0, 1'b1, 32'h600);
    send_beat(0, 32'h0BADCAFE, 4'h9, 1'b1, 1'b1, 32'h604);
    wait_b(0, OKAY);

    repeat (3) @(negedge clk);
    check("write_queue_drained", MW'(exp_q.size()), '0);
    check("b_queue_drained", MW'(exp_b_q.size()), '0);
`ifdef W_MEM_WRITER_STATS_EN
    check("stat_bursts", MW'(stat_bursts), MW'(11));
    check("stat_errors", MW'(stat_errors), MW'(4));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
